// File: rtl/ram16k_arbiter_if.sv
// Requester-side bus for the ram16k arbiter: request handshake plus read response.
// The requester drives the master modport; the arbiter takes the slave modport.
interface ram16k_arbiter_if;
  logic        valid;
  logic        ready;
  logic        we;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        rsp_valid;
  logic [15:0] rdata;

  modport master (
    output valid,
    output we,
    output addr,
    output wdata,
    input  ready,
    input  rsp_valid,
    input  rdata
  );

  modport slave (
    input  valid,
    input  we,
    input  addr,
    input  wdata,
    output ready,
    output rsp_valid,
    output rdata
  );
endinterface

// File: rtl/ram16k_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port ram16k.
// One access per cycle; writes land at the end of the grant cycle, reads return
// one cycle later as a single-cycle response pulse with registered data.
module ram16k_arbiter #(
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  ram16k_arbiter_if.slave    a,
  ram16k_arbiter_if.slave    b,
  output logic [15:0]        ram_in,
  output logic               ram_load,
  output logic [15:0]        ram_address,
  input  logic [15:0]        ram_out
);

  typedef enum logic {OwnA, OwnB} owner_e;

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] OneCnt = CNT_W'(1);

  owner_e           owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             cur_valid;
  logic             oth_valid;
  logic             grant_cur;
  logic             grant_oth;
  logic             grant_a;
  logic             grant_b;

  logic             rsp_a_q, rsp_b_q;
  logic [15:0]      rdata_a_q, rdata_b_q;

  // Round-robin decision: the owner keeps the port until its burst budget runs out
  // and the other side is waiting; an idle cycle restarts the budget.
  always_comb begin
    cur_valid = (owner_q == OwnA) ? a.valid : b.valid;
    oth_valid = (owner_q == OwnA) ? b.valid : a.valid;
    grant_cur = 1'b0;
    grant_oth = 1'b0;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    if (cur_valid && (cnt_q < MaxCnt)) begin
      grant_cur = 1'b1;
      cnt_d     = cnt_q + OneCnt;
    end else if (oth_valid) begin
      grant_oth = 1'b1;
      owner_d   = (owner_q == OwnA) ? OwnB : OwnA;
      cnt_d     = OneCnt;
    end else if (cur_valid) begin
      // Partner idle: keep streaming with the counter parked at its limit.
      grant_cur = 1'b1;
    end else begin
      cnt_d     = '0;
    end
  end

  // Map owner-relative grants back to requesters; nothing is granted in reset.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (rst_n) begin
      grant_a = (owner_q == OwnA) ? grant_cur : grant_oth;
      grant_b = (owner_q == OwnB) ? grant_cur : grant_oth;
    end
  end

  // Drive the RAM pins from the granted requester, all-zero when idle.
  always_comb begin
    ram_address = '0;
    ram_in      = '0;
    ram_load    = 1'b0;
    unique case ({grant_b, grant_a})
      2'b01: begin
        ram_address = a.addr;
        ram_in      = a.wdata;
        ram_load    = a.we;
      end
      2'b10: begin
        ram_address = b.addr;
        ram_in      = b.wdata;
        ram_load    = b.we;
      end
      default: begin
        ram_address = '0;
        ram_in      = '0;
        ram_load    = 1'b0;
      end
    endcase
  end

  // Arbitration state: current owner and consecutive-grant counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_q <= OwnA;
      cnt_q   <= '0;
    end else begin
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  // Read responses: capture the combinational RAM output at the end of a read grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_a_q   <= 1'b0;
      rsp_b_q   <= 1'b0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      rsp_a_q <= grant_a && !a.we;
      rsp_b_q <= grant_b && !b.we;
      if (grant_a && !a.we) begin
        rdata_a_q <= ram_out;
      end
      if (grant_b && !b.we) begin
        rdata_b_q <= ram_out;
      end
    end
  end

  assign a.ready     = grant_a;
  assign b.ready     = grant_b;
  assign a.rsp_valid = rsp_a_q;
  assign b.rsp_valid = rsp_b_q;
  assign a.rdata     = rdata_a_q;
  assign b.rdata     = rdata_b_q;

endmodule

// File: tb/tb_ram16k_arbiter.sv
// Bench for ram16k_arbiter: two instances (burst limit 4 and 1), each with its own
// RAM, driven from per-requester command queues and checked every cycle against
// a reference model of grants, RAM pins, memory contents and responses.
`timescale 1ns/1ps
module tb_ram16k_arbiter;

  typedef struct {
    bit          idle;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } cmd_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Requester index i = 2*d + r; d = 0 -> burst limit 4, d = 1 -> burst limit 1; r = 0 A, 1 B.
  logic [1:0]       rst_n;
  logic [3:0]       v, we;
  logic [3:0][15:0] addr, wdata;
  wire  [3:0]       rdy, rspv;
  wire  [3:0][15:0] rdat;
  wire  [1:0]       ram_load;
  wire  [1:0][15:0] ram_address, ram_in;

  for (genvar d = 0; d < 2; d++) begin : g_dut
    ram16k_arbiter_if ia ();
    ram16k_arbiter_if ib ();
    logic [15:0] ram_out;
    logic [15:0] mem [65536] = '{default: '0};

    assign ia.valid = v[2*d];
    assign ia.we    = we[2*d];
    assign ia.addr  = addr[2*d];
    assign ia.wdata = wdata[2*d];
    assign ib.valid = v[2*d+1];
    assign ib.we    = we[2*d+1];
    assign ib.addr  = addr[2*d+1];
    assign ib.wdata = wdata[2*d+1];
    assign rdy[2*d]    = ia.ready;
    assign rdy[2*d+1]  = ib.ready;
    assign rspv[2*d]   = ia.rsp_valid;
    assign rspv[2*d+1] = ib.rsp_valid;
    assign rdat[2*d]   = ia.rdata;
    assign rdat[2*d+1] = ib.rdata;

    ram16k_arbiter #(
      .MAX_BURST ((d == 0) ? 4 : 1),
      .CNT_W     (8)
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n[d]),
      .a           (ia),
      .b           (ib),
      .ram_in      (ram_in[d]),
      .ram_load    (ram_load[d]),
      .ram_address (ram_address[d]),
      .ram_out     (ram_out)
    );

    assign ram_out = mem[ram_address[d]];
    always @(posedge clk) begin
      if (ram_load[d]) mem[ram_address[d]] <= ram_in[d];
    end
  end

  int unsigned checks = 0;
  int unsigned errors = 0;

  cmd_t        q [4][$];
  int          maxb [2] = '{4, 1};
  int          owner [2];
  int          streak [2];
  bit          known [2];
  bit          pend_v [4];
  logic [15:0] exp_rdata [4];
  logic [15:0] ref_mem [2][65536];
  int          glog [2][$];
  logic [15:0] rlog [4][$];
  int          loads [2];
  logic [15:0] last_load_addr [2];
  logic [15:0] pre_a [8];
  logic [15:0] pre_b [4];
  int          exp_seq [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
  int          used;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s: observed %h required %h", tag, obs, req);
    end
  endtask

  function automatic logic [15:0] gl(input int d, input int k);
    return (k < glog[d].size()) ? 16'(glog[d][k]) : 16'hFFFF;
  endfunction

  function automatic logic [15:0] rl(input int i, input int k);
    return (k < rlog[i].size()) ? rlog[i][k] : 16'hFFFF;
  endfunction

  // Per-cycle reference check for one instance, then advance the model past the edge.
  task automatic tick(input int d);
    int          g, cur, oth, i;
    bit [1:0]    vv;
    logic        e_load;
    logic [15:0] e_addr, e_in;
    vv = {v[2*d+1], v[2*d]};
    g  = -1;
    if (rst_n[d]) begin
      cur = owner[d];
      oth = 1 - cur;
      if (vv[cur] && streak[d] < maxb[d]) g = cur;
      else if (vv[oth])                   g = oth;
      else if (vv[cur])                   g = cur;
    end
    e_load = 1'b0;
    e_addr = '0;
    e_in   = '0;
    if (g >= 0) begin
      i      = 2*d + g;
      e_load = we[i];
      e_addr = addr[i];
      e_in   = wdata[i];
    end
    chk($sformatf("d%0d a_ready", d), 16'(rdy[2*d]), 16'(g == 0));
    chk($sformatf("d%0d b_ready", d), 16'(rdy[2*d+1]), 16'(g == 1));
    chk($sformatf("d%0d ram_load", d), 16'(ram_load[d]), 16'(e_load));
    chk($sformatf("d%0d ram_address", d), ram_address[d], e_addr);
    chk($sformatf("d%0d ram_in", d), ram_in[d], e_in);
    if (known[d]) begin
      for (int r = 0; r < 2; r++) begin
        i = 2*d + r;
        chk($sformatf("d%0d r%0d rsp_valid", d, r), 16'(rspv[i]), 16'(pend_v[i]));
        chk($sformatf("d%0d r%0d rdata", d, r), rdat[i], exp_rdata[i]);
        if (rst_n[d] && rspv[i]) rlog[i].push_back(rdat[i]);
      end
    end
    if (ram_load[d]) begin
      loads[d]++;
      last_load_addr[d] = ram_address[d];
    end
    if (!rst_n[d]) begin
      known[d]  = 1'b1;
      owner[d]  = 0;
      streak[d] = 0;
      for (int r = 0; r < 2; r++) begin
        pend_v[2*d+r]    = 1'b0;
        exp_rdata[2*d+r] = '0;
      end
    end else begin
      pend_v[2*d]   = 1'b0;
      pend_v[2*d+1] = 1'b0;
      if (g >= 0) begin
        i = 2*d + g;
        glog[d].push_back(g);
        if (we[i]) begin
          ref_mem[d][addr[i]] = wdata[i];
        end else begin
          pend_v[i]    = 1'b1;
          exp_rdata[i] = ref_mem[d][addr[i]];
        end
        if (g == owner[d]) begin
          streak[d]++;
        end else begin
          owner[d]  = g;
          streak[d] = 1;
        end
      end else begin
        streak[d] = 0;
      end
    end
  endtask

  // One clock: present queue heads, check both instances, pop what was accepted.
  task automatic cycle();
    bit took [4];
    for (int i = 0; i < 4; i++) begin
      if (q[i].size() > 0 && !q[i][0].idle) begin
        v[i]     = 1'b1;
        we[i]    = q[i][0].we;
        addr[i]  = q[i][0].addr;
        wdata[i] = q[i][0].wdata;
      end else begin
        v[i]     = 1'b0;
        we[i]    = 1'b0;
        addr[i]  = '0;
        wdata[i] = '0;
      end
    end
    #1;
    tick(0);
    tick(1);
    for (int i = 0; i < 4; i++) took[i] = (q[i].size() > 0) && (q[i][0].idle || rdy[i]);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (took[i]) void'(q[i].pop_front());
  endtask

  task automatic drain(input string tag, input int limit, output int n);
    n = 0;
    while ((q[0].size() + q[1].size() + q[2].size() + q[3].size()) > 0 && n < limit) begin
      cycle();
      n++;
    end
    chk({tag, " drained"}, 16'(q[0].size() + q[1].size() + q[2].size() + q[3].size()), 16'd0);
    cycle();
    cycle();
  endtask

  task automatic push(input int i, input bit w, input logic [15:0] a, input logic [15:0] dat);
    cmd_t c;
    c.idle  = 1'b0;
    c.we    = w;
    c.addr  = a;
    c.wdata = dat;
    q[i].push_back(c);
  endtask

  task automatic push_idle(input int i);
    cmd_t c;
    c.idle  = 1'b1;
    c.we    = 1'b0;
    c.addr  = '0;
    c.wdata = '0;
    q[i].push_back(c);
  endtask

  task automatic clear_logs();
    for (int d = 0; d < 2; d++) begin
      glog[d].delete();
      loads[d] = 0;
      last_load_addr[d] = '0;
    end
    for (int i = 0; i < 4; i++) rlog[i].delete();
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 65536; k++) ref_mem[d][k] = '0;
      owner[d]  = 0;
      streak[d] = 0;
      known[d]  = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      pend_v[i]    = 1'b0;
      exp_rdata[i] = '0;
    end
    clear_logs();
    rst_n = 2'b00;

    // Reset held with both requesters offering writes: nothing may be accepted.
    push(0, 1'b1, 16'h0100, 16'h1111);
    push(1, 1'b1, 16'h0101, 16'h2222);
    repeat (3) cycle();
    chk("reset no accept A", 16'(q[0].size()), 16'd1);
    chk("reset no accept B", 16'(q[1].size()), 16'd1);
    chk("reset no load", 16'(loads[0]), 16'd0);
    rst_n[0] = 1'b1;
    clear_logs();
    cycle();
    chk("first grant after reset", gl(0, 0), 16'd0);
    drain("reset", 20, used);
    chk("release grants", gl(0, 1), 16'd1);

    // Burst limit 1: preload old value, then reset with both valid and release.
    rst_n[1] = 1'b1;
    push(2, 1'b1, 16'h0002, 16'h0011);
    drain("alt preload", 20, used);
    rst_n[1] = 1'b0;
    push(2, 1'b0, 16'h0002, 16'h0000);
    push(3, 1'b1, 16'h0002, 16'h0055);
    push(2, 1'b0, 16'h0002, 16'h0000);
    cycle();
    cycle();
    rst_n[1] = 1'b1;
    clear_logs();
    drain("alt", 20, used);
    chk("alt grant count", 16'(glog[1].size()), 16'd3);
    chk("alt grant 0", gl(1, 0), 16'd0);
    chk("alt grant 1", gl(1, 1), 16'd1);
    chk("alt grant 2", gl(1, 2), 16'd0);
    chk("alt old data", rl(2, 0), 16'h0011);
    chk("alt new data", rl(2, 1), 16'h0055);

    // Single requester write then read-back.
    clear_logs();
    push(0, 1'b1, 16'h1234, 16'hBEEF);
    push(0, 1'b0, 16'h1234, 16'h0000);
    drain("single", 20, used);
    chk("single load count", 16'(loads[0]), 16'd1);
    chk("single load addr", last_load_addr[0], 16'h1234);
    chk("single rsp count", 16'(rlog[0].size()), 16'd1);
    chk("single rdata", rl(0, 0), 16'hBEEF);
    chk("single b silent", 16'(rlog[1].size()), 16'd0);

    // Burst fairness with limit 4 from a fresh reset.
    for (int k = 0; k < 8; k++) begin
      pre_a[k] = 16'($urandom);
      push(0, 1'b1, 16'h0200 + 16'(k), pre_a[k]);
    end
    for (int k = 0; k < 4; k++) begin
      pre_b[k] = 16'($urandom);
      push(1, 1'b1, 16'h0300 + 16'(k), pre_b[k]);
    end
    drain("burst preload", 40, used);
    rst_n[0] = 1'b0;
    cycle();
    rst_n[0] = 1'b1;
    clear_logs();
    for (int k = 0; k < 8; k++) push(0, 1'b0, 16'h0200 + 16'(k), 16'h0000);
    for (int k = 0; k < 4; k++) push(1, 1'b0, 16'h0300 + 16'(k), 16'h0000);
    drain("burst", 40, used);
    chk("burst grant count", 16'(glog[0].size()), 16'd12);
    for (int k = 0; k < 12; k++) chk($sformatf("burst grant %0d", k), gl(0, k), 16'(exp_seq[k]));
    for (int k = 0; k < 8; k++) chk($sformatf("burst a data %0d", k), rl(0, k), pre_a[k]);
    for (int k = 0; k < 4; k++) chk($sformatf("burst b data %0d", k), rl(1, k), pre_b[k]);

    // Idle partner: ten back-to-back reads, no stall once the counter saturates.
    clear_logs();
    for (int k = 0; k < 10; k++) push(0, 1'b0, 16'h0200 + 16'(k % 8), 16'h0000);
    drain("idle partner", 40, used);
    chk("idle partner cycles", 16'(used), 16'd10);
    chk("idle partner grants", 16'(glog[0].size()), 16'd10);
    chk("idle partner pulses", 16'(rlog[0].size()), 16'd10);

    // Reset right after a read grant; a write offered during reset must not land.
    clear_logs();
    push(0, 1'b0, 16'h0201, 16'h0000);
    cycle();
    chk("midreset grant", 16'(glog[0].size()), 16'd1);
    push(0, 1'b1, 16'h0201, 16'hDEAD);
    rst_n[0] = 1'b0;
    cycle();
    q[0].delete();
    rst_n[0] = 1'b1;
    #1;
    chk("midreset rsp cleared", 16'(rspv[0]), 16'd0);
    chk("midreset rdata cleared", rdat[0], 16'h0000);
    clear_logs();
    push(1, 1'b0, 16'h0201, 16'h0000);
    push(0, 1'b0, 16'h0201, 16'h0000);
    drain("midreset", 20, used);
    chk("midreset a wins", gl(0, 0), 16'd0);
    chk("midreset no write", 16'(loads[0]), 16'd0);
    chk("midreset a data", rl(0, 0), pre_a[1]);
    chk("midreset b data", rl(1, 0), pre_a[1]);

    // Random traffic on both instances over a small address window.
    for (int i = 0; i < 4; i++) begin
      for (int n = 0; n < 60; n++) begin
        if ($urandom_range(0, 3) == 0) push_idle(i);
        else push(i, 1'($urandom_range(0, 1)), 16'h0400 + 16'($urandom_range(0, 7)),
                  16'($urandom));
      end
    end
    drain("random", 2000, used);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
